fc_feature_streamer: RTL and testbench
======================================

// Module: fc_feature_streamer
// PURPOSE
// Transmit side of the FC input stream. Accepts signed 32-bit pooled features over valid/ready.
// Requantizes each one to unsigned 8-bit and stores it in a ping-pong buffer.
// Sends each complete IN_DIM-element vector as one gap-free burst on out_data/out_valid, the FC unit's in_data/in_valid.
// Waits for the FC class_valid pulse (done_in) before it starts the next burst.
// PARAMETERS
// IN_DIM        32   elements per vector; must equal the FC IN_DIM (FC weight indexing fixes 32)
// SHIFT         8    requant arithmetic right shift, 1..30
// DONE_TIMEOUT  255  max cycles in TX_WAIT_DONE before forced release
// PORTS
// clk          in   1   clock, rising edge
// rst_n        in   1   reset, asynchronous, active-low
// s_data       in   32  signed feature value
// s_valid      in   1   s_data valid
// s_ready      out  1   buffer can accept; a handshake is s_valid&&s_ready
// s_last       in   1   marks the final element of a vector (length check only)
// out_data     out  8   unsigned feature byte to FC
// out_valid    out  1   out_data valid; high for exactly IN_DIM consecutive cycles per burst
// done_in      in   1   one-cycle pulse from FC class_valid
// busy         out  1   high in TX_BURST or TX_WAIT_DONE
// err_len      out  1   sticky: s_last mismatched the element count
// err_timeout  out  1   sticky: done_in missing for DONE_TIMEOUT cycles
// BEHAVIOUR
// Reset values: out_data=0, out_valid=0, busy=0, err_len=0, err_timeout=0, s_ready=1.
//   Internal reset: both banks empty, wr_bank=rd_bank=0, pointers 0, TX_IDLE.
// Requant (at write time): negative x -> 0; else y = x>>>SHIFT; y>255 -> 255. Entries are stored 8-bit.
// Fill: s_ready = !full[wr_bank], combinational from registers.
//   Each handshake writes entry wr_ptr and increments wr_ptr.
//   The handshake at wr_ptr==IN_DIM-1 sets full[wr_bank], toggles wr_bank and clears wr_ptr.
// Length check: s_last at wr_ptr!=IN_DIM-1, or no s_last at IN_DIM-1, sets err_len.
//   The bank commits on count only; s_last never truncates or extends a vector.
// TX FSM:
//   TX_IDLE: full[rd_bank] -> TX_BURST.
//   TX_BURST: rd_ptr runs 0..IN_DIM-1 with one byte per cycle and no bubbles.
//     After the last byte: clear full[rd_bank], toggle rd_bank, go to TX_WAIT_DONE, out_valid=0 next cycle.
//   TX_WAIT_DONE: timer counts from 0.
//     done_in -> TX_IDLE.
//     Timer reaching DONE_TIMEOUT -> set err_timeout, go to TX_IDLE.
// Latency: if the last element handshake is at edge N, byte 0 is valid from edge N+2.
//   After done_in at edge M, the next burst can start no earlier than edge M+2.
//   This guarantees the FC has returned to IDLE before the next burst.
// Simultaneous events:
//   - A fill commit and a burst release in the same cycle always hit different banks. Both take effect.
//   - The freed bank is writable (s_ready) in the next cycle.
//   - done_in outside TX_WAIT_DONE is ignored.
//   - done_in and timeout in the same cycle: done_in wins, err_timeout is not set.
// Full: both banks full -> s_ready=0 until a burst releases a bank. No input is ever dropped.
// Reset mid-operation: any partial vector and any burst in flight are discarded.
//   out_valid drops asynchronously, so the FC sees a short vector.
//   System reset must also cover the FC.
// CONFIGURATION
// REQUANT_ROUND_EN defined: y = (x + (1<<(SHIFT-1)))>>>SHIFT, round half up, then saturate.
//   The add is done at 33 bits so 32'h7FFFFFFF does not wrap.
// REQUANT_ROUND_EN undefined: truncating shift as described above. Timing and interfaces are identical.
// TESTING
// T1: x_k=k*256, k=0..31, s_last at k=31 -> out_valid 32 cycles, out_data 0..31 in order, err_len=0.
// T2: x=-5, 70000, 255, 384 -> bytes 0, 255, 0, 1 (with REQUANT_ROUND_EN: 0, 255, 1, 2).
// T3: 64 elements back-to-back, done_in pulsed 11 cycles after burst 1 ends ->
//     s_ready stays 1 for all 64; burst 2 starts 2 cycles after done_in.
// T4: 96 elements with no done_in -> s_ready=0 after element 64;
//     err_timeout=1 after 255 wait cycles; burst 2 follows and a bank frees.
// T5: s_last on element 20 -> err_len=1 and the burst is still 32 bytes;
//     then rst_n low mid-burst -> out_valid=0 at once, all outputs at reset values.
// T6: done_in pulses during TX_BURST and TX_IDLE -> ignored; WAIT_DONE still needs a later pulse.

Source files
------------

// File: rtl/fc_feature_streamer.sv
// Requantizing ping-pong feature buffer feeding the FC unit in gap-free IN_DIM-byte bursts.
// Define REQUANT_ROUND_EN for round-half-up requantization (default: truncating shift).
module fc_feature_streamer #(
  parameter int IN_DIM       = 32,
  parameter int SHIFT        = 8,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        done_in,
  output logic        busy,
  output logic        err_len,
  output logic        err_timeout
);

  // state        | meaning
  // TX_IDLE      | waiting for the read bank to become full
  // TX_BURST     | streaming one byte per cycle from the read bank
  // TX_WAIT_DONE | burst sent, waiting for done_in or the timeout
  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_BURST     = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_e;

  localparam int PTR_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int TMR_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IN_DIM - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);

`ifdef REQUANT_ROUND_EN
  localparam logic [32:0] RND = 33'd1 << (SHIFT - 1);
`else
  localparam logic [32:0] RND = 33'd0;
`endif

  // 33-bit add keeps 32'h7FFFFFFF plus the rounding constant from wrapping.
  function automatic logic [7:0] requant(input logic [31:0] x);
    logic [32:0] sum;
    logic [32:0] y;
    sum = {1'b0, x} + RND;
    y   = sum >> SHIFT;
    if (x[31])            requant = 8'd0;
    else if (y > 33'd255) requant = 8'd255;
    else                  requant = y[7:0];
  endfunction

  logic [7:0]       mem_q [2][IN_DIM];
  logic [7:0]       mem_d [2][IN_DIM];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  tx_state_e        state_q, state_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_len_q, err_len_d;
  logic             err_timeout_q, err_timeout_d;
  logic             hs;
  logic             rel;

  assign s_ready = !full_q[wr_bank_q];
  assign hs      = s_valid && s_ready;

  // Fill side; commit and release always target different banks.
  always_comb begin
    mem_d     = mem_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    err_len_d = err_len_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (hs) begin
      mem_d[wr_bank_q][wr_ptr_q] = requant(s_data);
      if (s_last != (wr_ptr_q == PTR_LAST)) err_len_d = 1'b1;
      if (wr_ptr_q == PTR_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_ptr_d          = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    rd_bank_d     = rd_bank_q;
    timer_d       = timer_q;
    out_data_d    = 8'd0;
    out_valid_d   = 1'b0;
    err_timeout_d = err_timeout_q;
    rel           = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = TX_BURST;
          rd_ptr_d = '0;
        end
      end
      TX_BURST: begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_bank_q][rd_ptr_q];
        if (rd_ptr_q == PTR_LAST) begin
          rel       = 1'b1;
          rd_bank_d = ~rd_bank_q;
          rd_ptr_d  = '0;
          timer_d   = '0;
          state_d   = TX_WAIT_DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      TX_WAIT_DONE: begin
        // done_in takes priority over a timeout in the same cycle.
        if (done_in) begin
          state_d = TX_IDLE;
        end else if (timer_q == TMR_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = TX_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q         <= '{default: '{default: 8'd0}};
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      timer_q       <= '0;
      state_q       <= TX_IDLE;
      out_data_q    <= 8'd0;
      out_valid_q   <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      timer_q       <= timer_d;
      state_q       <= state_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q == TX_BURST) || (state_q == TX_WAIT_DONE);
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fc_feature_streamer.sv
// Directed bench for fc_feature_streamer: vector table plus timing/timeout/reset sequences.
module tb_fc_feature_streamer;
  localparam int IN_DIM = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  exp_t;
    logic [7:0]  exp_r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        done_in = 1'b0;
  logic        s_ready, out_valid, busy, err_len, err_timeout;
  logic [7:0]  out_data;

  fc_feature_streamer dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .out_data(out_data), .out_valid(out_valid), .done_in(done_in),
    .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: checks each byte against the expected queue and each burst length.
  logic [7:0] exp_q[$];
  int n_starts = 0, n_ends = 0, run = 0;
  int start_a[32], end_a[32];
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run    = 0;
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_v) begin
          if (n_starts < 32) start_a[n_starts] = cyc;
          n_starts++;
        end
        run++;
        if (exp_q.size() == 0) chk("rx_extra_byte", exp_q.size(), 1);
        else chk("rx_byte", out_data, exp_q.pop_front());
      end else if (prev_v) begin
        if (n_ends < 32) end_a[n_ends] = cyc;
        n_ends++;
        chk("burst_len", run, IN_DIM);
        run = 0;
      end
      prev_v = out_valid;
    end
  end

  int hs_n = 0;
  int hs_a[128];
  int stalls = 0;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [7:0] e);
    int n = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    while (!s_ready && n < 1000) begin @(posedge clk); #1; n++; end
    stalls += n;
    if (!s_ready) begin
      chk("s_ready_wait", s_ready, 1);
    end else begin
      @(posedge clk); #1;
      exp_q.push_back(e);
      if (hs_n < 128) hs_a[hs_n] = cyc;
      hs_n++;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_ends(input int target, input int limit);
    int n = 0;
    while (n_ends < target && n < limit) begin @(posedge clk); #1; n++; end
    if (n_ends < target) chk("wait_burst_end", n_ends, target);
  endtask

  task automatic wait_starts(input int target, input int limit);
    int n = 0;
    while (n_starts < target && n < limit) begin @(posedge clk); #1; n++; end
    if (n_starts < target) chk("wait_burst_start", n_starts, target);
  endtask

  task automatic goto_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 2000) begin @(posedge clk); #1; n++; end
  endtask

  // done_in is sampled high by the DUT at edge number d.
  task automatic pulse_done_at(input int d);
    goto_cyc(d - 1);
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef REQUANT_ROUND_EN
    return v.exp_r;
`else
    return v.exp_t;
`endif
  endfunction

  vec_t vec [64];
  int bs, be, e1, d1;

  initial begin
    // Vector 1: k*256 -> k. Vector 2: requant corner cases, then j*512+100 -> 2j.
    for (int k = 0; k < 32; k++)
      vec[k] = '{32'(k * 256), (k == 31), 8'(k), 8'(k)};
    vec[32] = '{32'hFFFF_FFFB, 1'b0, 8'd0,   8'd0};
    vec[33] = '{32'd70000,     1'b0, 8'd255, 8'd255};
    vec[34] = '{32'd255,       1'b0, 8'd0,   8'd1};
    vec[35] = '{32'd384,       1'b0, 8'd1,   8'd2};
    vec[36] = '{32'h7FFF_FFFF, 1'b0, 8'd255, 8'd255};
    vec[37] = '{32'h8000_0000, 1'b0, 8'd0,   8'd0};
    vec[38] = '{32'd65535,     1'b0, 8'd255, 8'd255};
    vec[39] = '{32'd65280,     1'b0, 8'd255, 8'd255};
    vec[40] = '{32'd65279,     1'b0, 8'd254, 8'd255};
    vec[41] = '{32'd511,       1'b0, 8'd1,   8'd2};
    vec[42] = '{32'd127,       1'b0, 8'd0,   8'd0};
    vec[43] = '{32'd128,       1'b0, 8'd0,   8'd1};
    vec[44] = '{32'd32767,     1'b0, 8'd127, 8'd128};
    vec[45] = '{32'hFFFF_FFFF, 1'b0, 8'd0,   8'd0};
    vec[46] = '{32'd256,       1'b0, 8'd1,   8'd1};
    vec[47] = '{32'd0,         1'b0, 8'd0,   8'd0};
    for (int j = 0; j < 16; j++)
      vec[48 + j] = '{32'(j * 512 + 100), (j == 15), 8'(2 * j), 8'(2 * j)};

    // Reset values
    step(3);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    step(2);

    // Two vectors back to back, done_in 11 cycles after burst 1 ends
    hs_n = 0; stalls = 0; bs = n_starts; be = n_ends;
    fork
      begin
        for (int k = 0; k < 64; k++) send(vec[k].data, vec[k].last, pick(vec[k]));
      end
      begin
        wait_ends(be + 1, 400);
        e1 = end_a[be];
        pulse_done_at(e1 + 11);
        d1 = cyc;
        wait_ends(be + 2, 400);
      end
    join
    chk("t1_first_byte_latency", start_a[bs], hs_a[31] + 2);
    chk("t3_burst2_after_done", start_a[bs + 1], d1 + 2);
    chk("t3_no_stall", stalls, 0);
    chk("t1_err_len", err_len, 0);
    chk("t3_busy_in_wait", busy, 1);
    pulse_done_at(cyc + 1);
    step(1);
    chk("t3_idle_busy", busy, 0);
    chk("t3_queue_drained", exp_q.size(), 0);

    // done_in in IDLE and during BURST is ignored; done_in at the timeout edge wins
    done_in = 1'b1; step(1); done_in = 1'b0; step(1);
    chk("t6_idle_done_busy", busy, 0);
    bs = n_starts; be = n_ends;
    fork
      begin
        for (int k = 0; k < 32; k++) send(vec[k].data, vec[k].last, pick(vec[k]));
      end
      begin
        wait_starts(bs + 1, 200);
        pulse_done_at(start_a[bs] + 5);
        wait_ends(be + 1, 200);
        e1 = end_a[be];
        goto_cyc(e1 + 20);
        chk("t6_still_waiting", busy, 1);
        pulse_done_at(e1 + 254);
        chk("t6_done_wins_busy", busy, 0);
        chk("t6_done_wins_no_timeout", err_timeout, 0);
      end
    join

    // 96 elements, no done_in: timeout releases burst 2
    bs = n_starts; be = n_ends;
    fork
      begin
        for (int k = 0; k < 96; k++) begin
          send(32'(k * 256), ((k % 32) == 31), 8'(k));
          if (k == 63) chk("t4_full_after_64", s_ready, 0);
          if (k == 95) chk("t4_full_after_96", s_ready, 0);
        end
      end
      begin
        wait_ends(be + 1, 400);
        e1 = end_a[be];
        goto_cyc(e1 + 253);
        chk("t4_no_timeout_yet", err_timeout, 0);
        step(1);
        chk("t4_timeout", err_timeout, 1);
        wait_starts(bs + 2, 50);
        chk("t4_burst2_start", start_a[bs + 1], e1 + 256);
        wait_ends(be + 2, 100);
        chk("t4_bank_freed", s_ready, 1);
        pulse_done_at(cyc + 1);
        wait_ends(be + 3, 100);
        pulse_done_at(cyc + 1);
        step(1);
        chk("t4_timeout_sticky", err_timeout, 1);
        chk("t4_idle", busy, 0);
      end
    join

    // Early s_last, reset mid-burst, missing s_last
    rst_n = 1'b0; step(2); rst_n = 1'b1; step(1);
    chk("t5_timeout_cleared", err_timeout, 0);
    be = n_ends;
    for (int k = 0; k < 32; k++) begin
      send(32'(k * 256), (k == 20), 8'(k));
      if (k == 19) chk("t5_err_len_before", err_len, 0);
      if (k == 20) chk("t5_err_len_early", err_len, 1);
    end
    wait_ends(be + 1, 100);
    pulse_done_at(cyc + 1);
    step(1);

    bs = n_starts;
    for (int k = 0; k < 32; k++) send(32'(k * 256), (k == 31), 8'(k));
    wait_starts(bs + 1, 100);
    step(5);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_data", out_data, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_s_ready", s_ready, 1);
    chk("t5_rst_err_len", err_len, 0);
    chk("t5_rst_err_timeout", err_timeout, 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);

    be = n_ends;
    for (int k = 0; k < 32; k++) send(32'(k * 256 + 7), 1'b0, 8'(k));
    chk("t5_err_len_no_last", err_len, 1);
    wait_ends(be + 1, 100);
    pulse_done_at(cyc + 1);
    step(2);
    chk("t5_idle", busy, 0);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d n_bad=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
